// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types, default widths and the round-robin pick helper
//               for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;
  // Upper bound on requesters; IDs and padded vectors are sized for this.
  localparam int MAX_REQ    = 4;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  // One-hot pick of the first asserted request at or after ptr, wrapping
  // modulo num. Slots at or above num are never considered.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input req_id_t            ptr,
    input int unsigned        num
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    req_id_t            idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = req_id_t'((32'(ptr) + k) % num);
      if (k < num && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter slice. Masks excluded requesters, then
//               picks the first remaining request searching up from i_ptr.
// Ports       : i_req  - request vector
//               i_ptr  - search start index
//               i_excl - requesters barred from this arbitration
//               o_gnt  - one-hot winner
//               o_idx  - winner index (0 when none)
//               o_any  - a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  req_id_t            i_ptr,
  input  logic [NUM_REQ-1:0] i_excl,
  output logic [NUM_REQ-1:0] o_gnt,
  output req_id_t            o_idx,
  output logic               o_any
);

  localparam int unsigned c_num = unsigned'(NUM_REQ);

  logic [MAX_REQ-1:0] req_pad;
  logic [MAX_REQ-1:0] gnt_pad;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = i_req & ~i_excl;
    gnt_pad                = rr_pick(req_pad, i_ptr, c_num);
    o_gnt                  = gnt_pad[NUM_REQ-1:0];
    o_any                  = |gnt_pad;
    o_idx                  = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (gnt_pad[i]) o_idx = req_id_t'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a two-port memory (A = read, B = write, active-low
//               enables) between NUM_REQ requesters. Independent round-robin
//               per port, read-after-write hazard blocking, bounded read
//               burst lock and read-return routing by requester ID.
// Ports       : clk, rst                      - clock, sync active-high reset
//               req_wr_en/addr/data, wr_gnt   - write requests and grant
//               req_rd_en/addr/lock, rd_gnt   - read requests and grant
//               rd_valid, rd_data             - routed read return
//               mem_cenA, mem_aA              - memory read port
//               mem_cenB, mem_aB, mem_d       - memory write port
//               mem_q                         - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_wr_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  input  logic [NUM_REQ-1:0]        req_rd_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
  input  logic [NUM_REQ-1:0]        req_rd_lock,
  output logic [NUM_REQ-1:0]        rd_gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      mem_cenA,
  output logic [ADDR_W-1:0]         mem_aA,
  output logic                      mem_cenB,
  output logic [ADDR_W-1:0]         mem_aB,
  output logic [DATA_W-1:0]         mem_d,
  input  logic [DATA_W-1:0]         mem_q
);

  localparam int c_cnt_w = $clog2(LOCK_MAX + 1);
  typedef logic [c_cnt_w-1:0] cnt_t;
  localparam cnt_t    c_lock_max = cnt_t'(LOCK_MAX);
  localparam req_id_t c_last     = req_id_t'(NUM_REQ - 1);

  function automatic req_id_t next_id(input req_id_t id);
    return (id == c_last) ? '0 : id + req_id_t'(1);
  endfunction

  // Per-slot views, padded to MAX_REQ so a req_id_t can index them directly.
  logic [ADDR_W-1:0]  wr_addr_a [MAX_REQ];
  logic [DATA_W-1:0]  wr_data_a [MAX_REQ];
  logic [ADDR_W-1:0]  rd_addr_a [MAX_REQ];
  logic [MAX_REQ-1:0] rd_en_pad;
  logic [MAX_REQ-1:0] rd_lock_pad;

  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_slot
    if (gi < NUM_REQ) begin : g_used
      assign wr_addr_a[gi]   = req_wr_addr[gi*ADDR_W +: ADDR_W];
      assign wr_data_a[gi]   = req_wr_data[gi*DATA_W +: DATA_W];
      assign rd_addr_a[gi]   = req_rd_addr[gi*ADDR_W +: ADDR_W];
      assign rd_en_pad[gi]   = req_rd_en[gi];
      assign rd_lock_pad[gi] = req_rd_lock[gi];
    end else begin : g_unused
      assign wr_addr_a[gi]   = '0;
      assign wr_data_a[gi]   = '0;
      assign rd_addr_a[gi]   = '0;
      assign rd_en_pad[gi]   = 1'b0;
      assign rd_lock_pad[gi] = 1'b0;
    end
  end

  // Registered state
  req_id_t wr_ptr_q,   wr_ptr_d;
  req_id_t rd_ptr_q,   rd_ptr_d;
  logic    lock_vld_q, lock_vld_d;
  req_id_t lock_own_q, lock_own_d;
  cnt_t    lock_cnt_q, lock_cnt_d;
  logic    ret_vld_q [RD_LAT];
  req_id_t ret_id_q  [RD_LAT];

  // Arbiter hookup
  logic [NUM_REQ-1:0] wr_pick_gnt, rd_pick_gnt, rd_excl;
  req_id_t            wr_idx, rd_pick_idx;
  logic               wr_any, rd_pick_any;

  // Lock evaluation (feeds the read arbiter's exclude mask)
  logic               lock_hold, lock_win;
  logic [MAX_REQ-1:0] own_oh;

  // Read winner and return decode
  req_id_t            rd_win_idx;
  logic [NUM_REQ-1:0] rd_win_oh;
  logic               rd_win_any, hazard, rd_go, wr_go;
  logic [MAX_REQ-1:0] ret_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .i_req  (req_wr_en),
    .i_ptr  (wr_ptr_q),
    .i_excl ('0),
    .o_gnt  (wr_pick_gnt),
    .o_idx  (wr_idx),
    .o_any  (wr_any)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .i_req  (req_rd_en),
    .i_ptr  (rd_ptr_q),
    .i_excl (rd_excl),
    .o_gnt  (rd_pick_gnt),
    .o_idx  (rd_pick_idx),
    .o_any  (rd_pick_any)
  );

  // The owner keeps winning while it holds en+lock and is under budget. Once
  // the budget is spent it sits out exactly one arbitration.
  always_comb begin
    lock_hold          = lock_vld_q & rd_en_pad[lock_own_q] & rd_lock_pad[lock_own_q];
    lock_win           = lock_hold & (lock_cnt_q < c_lock_max);
    own_oh             = '0;
    own_oh[lock_own_q] = 1'b1;
    rd_excl            = (lock_hold & ~lock_win) ? own_oh[NUM_REQ-1:0] : '0;
  end

  always_comb begin
    // Write port; rst idles both ports so the memory sees no stray access.
    wr_go    = wr_any & ~rst;
    wr_gnt   = wr_go ? wr_pick_gnt : '0;
    mem_cenB = ~wr_go;
    mem_aB   = wr_go ? wr_addr_a[wr_idx] : '0;
    mem_d    = wr_go ? wr_data_a[wr_idx] : '0;
    wr_ptr_d = wr_go ? next_id(wr_idx) : wr_ptr_q;

    // Read port
    rd_win_idx = lock_win ? lock_own_q : rd_pick_idx;
    rd_win_oh  = lock_win ? own_oh[NUM_REQ-1:0] : rd_pick_gnt;
    rd_win_any = (lock_win | rd_pick_any) & ~rst;
    // A read colliding with this cycle's write would return stale data; hold
    // it off a cycle without consuming a lock grant or moving the pointer.
    hazard     = wr_go & (rd_addr_a[rd_win_idx] == wr_addr_a[wr_idx]);
    rd_go      = rd_win_any & ~hazard;
    rd_gnt     = rd_go ? rd_win_oh : '0;
    mem_cenA   = ~rd_go;
    mem_aA     = rd_go ? rd_addr_a[rd_win_idx] : '0;

    // Pointer stays at owner+1 for the whole lock (set when the lock was
    // taken), so a release needs only to clear the lock fields.
    rd_ptr_d   = rd_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    if (lock_vld_q && !lock_win) begin
      lock_vld_d = 1'b0;
      lock_cnt_d = '0;
    end
    if (rd_go) begin
      if (lock_win) begin
        lock_cnt_d = lock_cnt_q + cnt_t'(1);
      end else begin
        rd_ptr_d = next_id(rd_win_idx);
        if (rd_lock_pad[rd_win_idx]) begin
          lock_vld_d = 1'b1;
          lock_own_d = rd_win_idx;
          lock_cnt_d = cnt_t'(1);
        end
      end
    end

    // Read return
    ret_oh                       = '0;
    ret_oh[ret_id_q[RD_LAT-1]]   = 1'b1;
    rd_valid = (ret_vld_q[RD_LAT-1] & ~rst) ? ret_oh[NUM_REQ-1:0] : '0;
    rd_data  = mem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
      lock_cnt_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        ret_vld_q[i] <= 1'b0;
        ret_id_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lock_vld_q   <= lock_vld_d;
      lock_own_q   <= lock_own_d;
      lock_cnt_q   <= lock_cnt_d;
      ret_vld_q[0] <= rd_go;
      ret_id_q[0]  <= rd_win_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        ret_vld_q[i] <= ret_vld_q[i-1];
        ret_id_q[i]  <= ret_id_q[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a behavioural
//               64x16 memory, a reference model and a read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int RL = 1;
  localparam int LM = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_wr_en, req_rd_en, req_rd_lock, wr_gnt, rd_gnt, rd_valid;
  logic [N*AW-1:0] req_wr_addr, req_rd_addr;
  logic [N*DW-1:0] req_wr_data;
  logic [DW-1:0]   rd_data, mem_d, mem_q;
  logic [AW-1:0]   mem_aA, mem_aB;
  logic            mem_cenA, mem_cenB;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .req_wr_en(req_wr_en), .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data), .wr_gnt(wr_gnt),
    .req_rd_en(req_rd_en), .req_rd_addr(req_rd_addr), .req_rd_lock(req_rd_lock), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_cenA(mem_cenA), .mem_aA(mem_aA), .mem_cenB(mem_cenB), .mem_aB(mem_aB),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  // Behavioural memory, one cycle read latency
  logic [DW-1:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (!mem_cenB) mem[mem_aB] <= mem_d;
    if (!mem_cenA) mem_q <= mem[mem_aA];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int id; logic [DW-1:0] data; int due; } exp_t;
  exp_t sb[$];

  logic [DW-1:0] ref_mem [64];
  int m_wptr, m_rptr, m_own, m_cnt;
  int cur_wr, cur_rd;
  logic [N-1:0] s_wr_gnt, s_rd_gnt;
  logic s_cenA, s_cenB;

  function automatic int wa(input int i); return int'(req_wr_addr[i*AW +: AW]); endfunction
  function automatic int ra(input int i); return int'(req_rd_addr[i*AW +: AW]); endfunction
  function automatic logic [DW-1:0] wd(input int i); return req_wr_data[i*DW +: DW]; endfunction

  // Evaluates the current cycle: decides who should win each port, checks the
  // DUT against that, books expected read returns, advances model state.
  task automatic step_check();
    int w, r, excl, idx;
    bit locked;
    w = -1; r = -1;
    if (rst) begin
      m_wptr = 0; m_rptr = 0; m_own = -1; m_cnt = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_wptr + k) % N;
        if (w < 0 && req_wr_en[idx]) w = idx;
      end
      excl = -1; locked = 0;
      if (m_own >= 0) begin
        if (req_rd_en[m_own] && req_rd_lock[m_own] && m_cnt < LM) begin
          r = m_own; locked = 1;
        end else begin
          if (req_rd_en[m_own] && req_rd_lock[m_own]) excl = m_own;
          m_rptr = (m_own + 1) % N; m_own = -1; m_cnt = 0;
        end
      end
      if (r < 0) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rptr + k) % N;
          if (r < 0 && idx != excl && req_rd_en[idx]) r = idx;
        end
      end
      if (r >= 0 && w >= 0 && ra(r) == wa(w)) r = -1;
      if (r >= 0) begin
        if (locked) m_cnt++;
        else begin
          m_rptr = (r + 1) % N;
          if (req_rd_lock[r]) begin m_own = r; m_cnt = 1; end
        end
        sb.push_back('{r, ref_mem[ra(r)], cyc + RL});
      end
      if (w >= 0) begin
        m_wptr = (w + 1) % N;
        ref_mem[wa(w)] = wd(w);
      end
    end
    chk("wr_gnt",   64'(wr_gnt),   64'(oh(w)));
    chk("mem_cenB", 64'(mem_cenB), 64'(w < 0));
    chk("mem_aB",   64'(mem_aB),   (w < 0) ? 64'd0 : 64'(wa(w)));
    chk("mem_d",    64'(mem_d),    (w < 0) ? 64'd0 : 64'(wd(w)));
    chk("rd_gnt",   64'(rd_gnt),   64'(oh(r)));
    chk("mem_cenA", 64'(mem_cenA), 64'(r < 0));
    chk("mem_aA",   64'(mem_aA),   (r < 0) ? 64'd0 : 64'(ra(r)));
    cur_wr = w; cur_rd = r;
    s_wr_gnt = wr_gnt; s_rd_gnt = rd_gnt; s_cenA = mem_cenA; s_cenB = mem_cenB;
  endtask

  // ---------------- read-return monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      sb.delete();
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rd_valid", 64'(rd_valid), 64'(oh(sb[0].id)));
      chk("rd_data",  64'(rd_data),  64'(sb[0].data));
      void'(sb.pop_front());
    end else if (rd_valid != '0) begin
      chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    step_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int i, input bit en, input int a, input logic [DW-1:0] d);
    req_wr_en[i] = en;
    req_wr_addr[i*AW +: AW] = AW'(a);
    req_wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input bit en, input int a, input bit lk);
    req_rd_en[i]   = en;
    req_rd_addr[i*AW +: AW] = AW'(a);
    req_rd_lock[i] = lk;
  endtask

  task automatic clear_all();
    req_wr_en = '0; req_rd_en = '0; req_rd_lock = '0;
    req_wr_addr = '0; req_rd_addr = '0; req_wr_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int a0, first1, idle;
  int cnts [N];

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    clear_all();
    rst = 1'b1;
    tick();
    chk("reset_wr_gnt", 64'(s_wr_gnt), 64'd0);
    chk("reset_cenA",   64'(s_cenA),   64'd1);
    rst = 1'b0;

    // Write then read back through requester 0
    set_wr(0, 1, 5, 16'h0019); tick();
    chk("t1_wr_gnt", 64'(s_wr_gnt), 64'd1);
    set_wr(0, 0, 0, '0); set_rd(0, 1, 5, 0); tick();
    chk("t1_rd_gnt", 64'(s_rd_gnt), 64'd1);
    set_rd(0, 0, 0, 0); tick();

    // Write alternation from wr_ptr = 0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_wr(0, 1, 10, 16'(k)); set_wr(1, 1, 20, 16'(k + 100));
      tick();
      chk("t2_wr_alt", 64'(s_wr_gnt), (k % 2 == 0) ? 64'd1 : 64'd2);
    end
    clear_all();

    // Read/write hazard on address 9
    set_rd(1, 1, 9, 0); set_wr(0, 1, 9, 16'hBEEF); tick();
    chk("t3_hazard_rd_gnt", 64'(s_rd_gnt), 64'd0);
    chk("t3_hazard_cenA",   64'(s_cenA),   64'd1);
    set_wr(0, 0, 0, '0); tick();
    chk("t3_retry_rd_gnt", 64'(s_rd_gnt), 64'd2);
    clear_all(); tick();

    // Randomized traffic with narrow addresses to provoke hazards
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (cur_wr == i || !req_wr_en[i])
          set_wr(i, $urandom_range(0, 2) != 0, $urandom_range(0, 7), 16'($urandom));
        if (cur_rd == i || !req_rd_en[i])
          set_rd(i, $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 3) == 0);
      end
    end
    clear_all(); tick(); tick();

    // Locked burst from requester 0 against a competing requester 1
    do_reset();
    a0 = 0; first1 = -1; idle = 0;
    set_rd(1, 1, 40, 0);
    for (int c = 0; c < 300 && a0 < 70; c++) begin
      set_rd(0, 1, a0 % 64, 1);
      tick();
      if (s_rd_gnt[1] && first1 < 0) first1 = c;
      if (s_rd_gnt == '0) idle++;
      if (cur_rd == 0) a0++;
    end
    chk("t4_burst_done",   64'(a0),     64'd70);
    chk("t4_first_r1_gnt", 64'(first1), 64'(LM));
    chk("t4_no_idle",      64'(idle),   64'd0);
    clear_all(); tick();

    // Reset right after a read grant
    do_reset();
    set_rd(0, 1, 3, 0); tick();
    chk("t5_pre_rd_gnt", 64'(s_rd_gnt), 64'd1);
    set_rd(0, 0, 0, 0); set_wr(1, 1, 7, 16'h1234);
    rst = 1'b1; tick();
    chk("t5_rst_cenA", 64'(s_cenA), 64'd1);
    chk("t5_rst_cenB", 64'(s_cenB), 64'd1);
    rst = 1'b0; clear_all();
    set_rd(0, 1, 11, 0); set_rd(1, 1, 12, 0); tick();
    chk("t5_post_rst_gnt", 64'(s_rd_gnt), 64'd1);
    clear_all(); tick();

    // Three-way read fairness
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnts[i] = 0;
      set_rd(i, 1, $urandom_range(0, 63), 0);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (s_rd_gnt[i]) cnts[i]++;
        if (cur_rd == i) set_rd(i, 1, $urandom_range(0, 63), 0);
      end
    end
    for (int i = 0; i < N; i++) chk("t6_fair_count", 64'(cnts[i]), 64'd10);
    clear_all();

    tick(); tick(); tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
